// File: rtl/mmul_parallel_iter_ctrl.sv
// Iteration sequencer for the MMUL_PARALLEL engine: launches the in1/in2/out_r streamers and the
// engine once per iteration at base+offset, waits for both completions, then advances the offset.
module mmul_parallel_iter_ctrl #(
    parameter int ADDR_W = 32,
    parameter int ITER_W = 16,
    parameter int LEN_W  = 11
) (
    input  logic              clk_i,
    input  logic              clear_i,
    input  logic              start_i,
    input  logic [ITER_W-1:0] nb_iter_i,
    input  logic [LEN_W-1:0]  len_iter_i,
    input  logic [ADDR_W-1:0] stride_i,
    input  logic [ADDR_W-1:0] base_in1_i,
    input  logic [ADDR_W-1:0] base_in2_i,
    input  logic [ADDR_W-1:0] base_out_i,
    input  logic              in1_ready_i,
    input  logic              in2_ready_i,
    input  logic              out_ready_i,
    input  logic              out_done_i,
    input  logic              eng_done_i,
    output logic              in1_start_o,
    output logic              in2_start_o,
    output logic              out_start_o,
    output logic [ADDR_W-1:0] in1_addr_o,
    output logic [ADDR_W-1:0] in2_addr_o,
    output logic [ADDR_W-1:0] out_addr_o,
    output logic [LEN_W-1:0]  xfer_len_o,
    output logic              eng_start_o,
    output logic              eng_clear_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [ITER_W-1:0] iter_cnt_o
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        COMPUTE,
        WAIT,
        UPDATEIDX,
        TERMINATE
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] stride_q;
    logic [ADDR_W-1:0] base_in1_q;
    logic [ADDR_W-1:0] base_in2_q;
    logic [ADDR_W-1:0] base_out_q;
    logic [ITER_W-1:0] nb_iter_q;
    logic [LEN_W-1:0]  len_iter_q;
    logic [ITER_W-1:0] iter_cnt;
    logic              eng_seen;
    logic              out_seen;

    logic              launch;
    logic              eng_hit;
    logic              out_hit;
    logic [ITER_W-1:0] iter_inc;

    assign launch   = (state == START) && in1_ready_i && in2_ready_i && out_ready_i;
    assign eng_hit  = eng_seen || eng_done_i;
    assign out_hit  = out_seen || out_done_i;
    assign iter_inc = iter_cnt + ITER_W'(1);

    assign in1_addr_o = base_in1_q + offset;
    assign in2_addr_o = base_in2_q + offset;
    assign out_addr_o = base_out_q + offset;
    assign xfer_len_o = len_iter_q;
    assign iter_cnt_o = iter_cnt;

    always_comb begin
        state_next  = state;
        in1_start_o = 1'b0;
        in2_start_o = 1'b0;
        out_start_o = 1'b0;
        eng_start_o = 1'b0;
        eng_clear_o = 1'b0;
        done_o      = 1'b0;
        busy_o      = (state != IDLE);
        case (state)
            IDLE: begin
                if (start_i) begin
                    // An empty job still produces a done pulse so software sees completion
                    if (nb_iter_i == '0 || len_iter_i == '0) state_next = TERMINATE;
                    else                                     state_next = START;
                end
            end
            START: begin
                if (launch) begin
                    in1_start_o = 1'b1;
                    in2_start_o = 1'b1;
                    out_start_o = 1'b1;
                    eng_start_o = 1'b1;
                    state_next  = COMPUTE;
                end
            end
            COMPUTE: begin
                if (eng_hit) state_next = WAIT;
            end
            WAIT: begin
                if (eng_hit && out_hit) state_next = UPDATEIDX;
            end
            UPDATEIDX: begin
                state_next = (iter_inc == nb_iter_q) ? TERMINATE : START;
            end
            TERMINATE: begin
                done_o      = 1'b1;
                eng_clear_o = 1'b1;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            state      <= IDLE;
            offset     <= '0;
            stride_q   <= '0;
            base_in1_q <= '0;
            base_in2_q <= '0;
            base_out_q <= '0;
            nb_iter_q  <= '0;
            len_iter_q <= '0;
            iter_cnt   <= '0;
            eng_seen   <= 1'b0;
            out_seen   <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        nb_iter_q  <= nb_iter_i;
                        len_iter_q <= len_iter_i;
                        stride_q   <= stride_i;
                        base_in1_q <= base_in1_i;
                        base_in2_q <= base_in2_i;
                        base_out_q <= base_out_i;
                        offset     <= '0;
                        iter_cnt   <= '0;
                    end
                end
                START: begin
                    if (launch) begin
                        eng_seen <= 1'b0;
                        out_seen <= 1'b0;
                    end
                end
                // Completions may arrive in either order, so both are remembered until the next launch
                COMPUTE, WAIT: begin
                    if (eng_done_i) eng_seen <= 1'b1;
                    if (out_done_i) out_seen <= 1'b1;
                end
                UPDATEIDX: begin
                    iter_cnt <= iter_inc;
                    offset   <= offset + stride_q;
                end
                default: ;
            endcase
        end
    end

endmodule
